// File: rtl/poly_voice_engine_if.sv
// Control/status bundle for the poly_voice_engine: register-write port, sample
// strobe and the mixed PCM output with its status flags.
interface poly_voice_engine_if #(
  parameter int VOICES      = 4,
  parameter int BITDEPTH    = 14,
  parameter int BITFRACTION = 6
) ();
  localparam int PHASEW = BITDEPTH + BITFRACTION;
  localparam int LOGV   = $clog2(VOICES);

  logic                sample_tick;
  logic                wr_en;
  logic [LOGV-1:0]     wr_voice;
  logic [1:0]          wr_addr;
  logic [PHASEW-1:0]   wr_data;
  logic [BITDEPTH-1:0] out;
  logic                out_valid;
  logic                busy;
  logic [VOICES-1:0]   active;

  modport master (
    output sample_tick, wr_en, wr_voice, wr_addr, wr_data,
    input  out, out_valid, busy, active
  );

  modport slave (
    input  sample_tick, wr_en, wr_voice, wr_addr, wr_data,
    output out, out_valid, busy, active
  );
endinterface

// File: rtl/poly_voice_engine.sv
// Time-multiplexed N-voice oscillator/envelope/mixer: one voice per clock after
// each sample tick, followed by a mix clock that produces one unsigned PCM word.
module poly_voice_engine #(
  parameter int VOICES      = 4,
  parameter int BITDEPTH    = 14,
  parameter int BITFRACTION = 6,
  parameter int VOLBITS     = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  poly_voice_engine_if.slave   bus
);
  localparam int PHASEW = BITDEPTH + BITFRACTION;
  localparam int LOGV   = $clog2(VOICES);
  localparam int PRODW  = BITDEPTH + VOLBITS + 2;
  // One extra bit beyond the worst-case sum of VOICES midscale-centred samples.
  localparam int SUMW   = BITDEPTH + LOGV + 1;

  localparam logic [BITDEPTH-1:0] MID  = {1'b1, {(BITDEPTH-1){1'b0}}};
  localparam logic [VOLBITS-1:0]  VMAX = '1;
  localparam logic [LOGV-1:0]     LAST = LOGV'(VOICES - 1);

  typedef enum logic [1:0] {
    ENV_IDLE,
    ENV_ATTACK,
    ENV_SUSTAIN,
    ENV_RELEASE
  } env_t;

  typedef struct packed {
    env_t               st;
    logic [VOLBITS-1:0] vol;
  } env_res_t;

  typedef enum logic [1:0] {
    SEQ_IDLE,
    SEQ_SLOT,
    SEQ_MIX
  } seq_t;

  // Gate high always heads toward max (from any state); gate low always heads
  // toward IDLE. Both the state change and the new volume land in one step.
  function automatic env_res_t env_step(input env_t st, input logic [VOLBITS-1:0] vol,
                                        input logic gate, input logic [VOLBITS-1:0] atk,
                                        input logic [VOLBITS-1:0] rel);
    env_res_t         r;
    logic [VOLBITS:0] up;
    r.st  = st;
    r.vol = vol;
    up    = {1'b0, vol} + {1'b0, atk};
    if (gate) begin
      if ((atk == '0) || (up >= {1'b0, VMAX})) begin
        r.st  = ENV_SUSTAIN;
        r.vol = VMAX;
      end else begin
        r.st  = ENV_ATTACK;
        r.vol = up[VOLBITS-1:0];
      end
    end else if (st == ENV_IDLE) begin
      r.vol = '0;
    end else if ((rel == '0) || (vol <= rel)) begin
      r.st  = ENV_IDLE;
      r.vol = '0;
    end else begin
      r.st  = ENV_RELEASE;
      r.vol = vol - rel;
    end
    return r;
  endfunction

  function automatic logic [BITDEPTH-1:0] wave_gen(input logic [2:0] sel,
                                                   input logic [BITDEPTH-1:0] p);
    logic [BITDEPTH-1:0] tri_w;
    logic [BITDEPTH-1:0] sq_w;
    logic [BITDEPTH-1:0] acc;
    tri_w = p[BITDEPTH-1] ? ~(p << 1) : (p << 1);
    sq_w  = {BITDEPTH{p[BITDEPTH-1]}};
    acc   = '1;
    if (sel[0]) acc = acc & tri_w;
    if (sel[1]) acc = acc & p;
    if (sel[2]) acc = acc & sq_w;
    if (sel == 3'b000) acc = MID;
    return acc;
  endfunction

  // Centre the wave on zero, scale by volume, floor via arithmetic shift.
  function automatic logic signed [PRODW-1:0] scale(input logic [BITDEPTH-1:0] w,
                                                    input logic [VOLBITS-1:0] v);
    logic signed [BITDEPTH:0]  s;
    logic signed [VOLBITS:0]   vs;
    logic signed [PRODW-1:0]   prod;
    s    = $signed({1'b0, w}) - $signed({1'b0, MID});
    vs   = $signed({1'b0, v});
    prod = PRODW'(s) * PRODW'(vs);
    return prod >>> VOLBITS;
  endfunction

  logic [PHASEW-1:0]  inc_q  [VOICES];
  logic [2:0]         sel_q  [VOICES];
  logic [VOLBITS-1:0] atk_q  [VOICES];
  logic [VOLBITS-1:0] rel_q  [VOICES];
  logic [VOICES-1:0]  gate_q;

  logic [PHASEW-1:0]  phase_q [VOICES];
  logic [VOLBITS-1:0] vol_q   [VOICES];
  env_t               env_q   [VOICES];
  logic [VOICES-1:0]  active_q;

  seq_t                  seq_q;
  logic [LOGV-1:0]       slot_q;
  logic signed [SUMW-1:0] sum_q;
  logic [BITDEPTH-1:0]   out_q;
  logic                  out_valid_q;
  logic                  busy_q;

  logic [PHASEW-1:0]       phase_d;
  env_res_t                env_d;
  logic [BITDEPTH-1:0]     wave_d;
  logic signed [PRODW-1:0] scaled_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < VOICES; i++) begin
        inc_q[i] <= '0;
        sel_q[i] <= '0;
        atk_q[i] <= '0;
        rel_q[i] <= '0;
      end
      gate_q <= '0;
    end else if (bus.wr_en) begin
      case (bus.wr_addr)
        2'd0: inc_q[bus.wr_voice] <= bus.wr_data;
        2'd1: begin
          sel_q[bus.wr_voice]  <= bus.wr_data[2:0];
          gate_q[bus.wr_voice] <= bus.wr_data[4];
        end
        2'd2: begin
          atk_q[bus.wr_voice] <= bus.wr_data[8 +: VOLBITS];
          rel_q[bus.wr_voice] <= bus.wr_data[0 +: VOLBITS];
        end
        default: ;
      endcase
    end
  end

  // Slot datapath: everything for the voice selected by slot_q, in one clock.
  always_comb begin
    phase_d  = phase_q[slot_q] + inc_q[slot_q];
    env_d    = env_step(env_q[slot_q], vol_q[slot_q], gate_q[slot_q],
                        atk_q[slot_q], rel_q[slot_q]);
    wave_d   = wave_gen(sel_q[slot_q], phase_d[PHASEW-1 -: BITDEPTH]);
    scaled_d = scale(wave_d, env_d.vol);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < VOICES; i++) begin
        phase_q[i] <= '0;
        vol_q[i]   <= '0;
        env_q[i]   <= ENV_IDLE;
      end
      active_q <= '0;
    end else if (seq_q == SEQ_SLOT) begin
      phase_q[slot_q]  <= phase_d;
      vol_q[slot_q]    <= env_d.vol;
      env_q[slot_q]    <= env_d.st;
      active_q[slot_q] <= (env_d.st != ENV_IDLE);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seq_q       <= SEQ_IDLE;
      slot_q      <= '0;
      sum_q       <= '0;
      out_q       <= MID;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      out_valid_q <= 1'b0;
      case (seq_q)
        SEQ_IDLE: begin
          if (bus.sample_tick) begin
            busy_q <= 1'b1;
            slot_q <= '0;
            seq_q  <= SEQ_SLOT;
          end
        end
        SEQ_SLOT: begin
          sum_q  <= (slot_q == '0) ? SUMW'(scaled_d) : (sum_q + SUMW'(scaled_d));
          slot_q <= slot_q + 1'b1;
          if (slot_q == LAST) seq_q <= SEQ_MIX;
        end
        SEQ_MIX: begin
          out_q       <= BITDEPTH'(sum_q >>> LOGV) + MID;
          out_valid_q <= 1'b1;
          busy_q      <= 1'b0;
          seq_q       <= SEQ_IDLE;
        end
        default: seq_q <= SEQ_IDLE;
      endcase
    end
  end

  assign bus.out       = out_q;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = busy_q;
  assign bus.active    = active_q;
endmodule
